// File: rtl/nibble_pack_fifo.sv
// nibble_pack_fifo
// Packs pairs of captured nibbles (low nibble first) into bytes and queues
// them in a small first-word-fall-through FIFO with a valid/ready output.
// A +1 (mod 16) sequence checker watches the nibble stream.
//
// Ports:
//   clk_b         receive-domain clock, rising edge
//   rst_n         asynchronous active-low reset
//   nib_valid     one-cycle strobe, nib_data holds a new nibble
//   nib_data      captured nibble
//   out_ready     downstream accepts out_data this cycle
//   out_valid     FIFO non-empty
//   out_data      head-of-FIFO byte (reads 0 while empty)
//   fifo_count    bytes stored, 0..DEPTH
//   half_pending  low nibble held, waiting for the high nibble
//   overflow      sticky: completed byte dropped because the FIFO was full
//   seq_err       sticky: a nibble broke the +1 sequence
//   clr_err       pulse: clears overflow/seq_err and disarms the checker
module nibble_pack_fifo #(
    parameter int ADDR_W = 2
) (
    input  logic              clk_b,
    input  logic              rst_n,
    input  logic              nib_valid,
    input  logic [3:0]        nib_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [7:0]        out_data,
    output logic [ADDR_W:0]   fifo_count,
    output logic              half_pending,
    output logic              overflow,
    output logic              seq_err,
    input  logic              clr_err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic [3:0]        low_nib;
    logic [3:0]        expected;
    logic              armed;

    logic push_req;
    logic pop;
    logic full;
    logic push_ok;
    logic drop;
    logic bad_nib;

    assign out_valid  = (count != '0);
    assign fifo_count = count;
    assign full       = (count == FULL_CNT);
    assign push_req   = nib_valid && half_pending;
    // Pop is qualified by out_valid before the edge, so a push into an
    // empty FIFO is never consumed at the same edge.
    assign pop        = out_valid && out_ready;
    // When full, a simultaneous pop frees the slot the push writes into.
    assign push_ok    = push_req && (!full || pop);
    assign drop       = push_req && full && !pop;
    assign bad_nib    = nib_valid && armed && (nib_data != expected);

    // Memory is not reset; empty reads are masked to zero instead.
    assign out_data   = out_valid ? mem[rd_ptr] : 8'h00;

    always_ff @(posedge clk_b) begin
        if (push_ok) begin
            mem[wr_ptr] <= {nib_data, low_nib};
        end
    end

    always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            low_nib      <= '0;
            half_pending <= 1'b0;
            overflow     <= 1'b0;
            seq_err      <= 1'b0;
            expected     <= '0;
            armed        <= 1'b0;
        end else begin
            if (nib_valid) begin
                if (half_pending) begin
                    half_pending <= 1'b0;
                end else begin
                    low_nib      <= nib_data;
                    half_pending <= 1'b1;
                end
            end

            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // Error set takes priority over a coincident clear.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end

            if (bad_nib) begin
                seq_err <= 1'b1;
            end else if (clr_err) begin
                seq_err <= 1'b0;
            end

            // The checker always resyncs to the latest nibble. A nibble
            // arriving with clr_err counts as the first one after the clear.
            if (nib_valid) begin
                expected <= nib_data + 4'd1;
                armed    <= 1'b1;
            end else if (clr_err) begin
                armed    <= 1'b0;
            end
        end
    end

endmodule

// File: doc/nibble_pack_fifo.md
Name: nibble_pack_fifo

Overview:
Consumer stage directly downstream of the clk_b-side handshake receiver. It takes each 4-bit nibble the receiver captures and packs nibble pairs into bytes. The bytes go into a small first-word-fall-through FIFO with a valid/ready output. It also checks that the nibble stream increments by 1 (mod 16), which is the pattern the clk_a driver produces, and flags overflow and sequence errors.

Parameters:
ADDR_W, 2, FIFO address width; depth DEPTH = 2**ADDR_W entries of 8 bits.

Ports:
clk_b  input  1  receive-domain clock; all logic on its rising edge.
rst_n  input  1  asynchronous active-low reset.
nib_valid  input  1  one-cycle strobe: nib_data holds a newly captured nibble.
nib_data  input  4  captured nibble.
out_ready  input  1  downstream accepts out_data this cycle.
out_valid  output  1  FIFO non-empty.
out_data  output  8  head-of-FIFO byte (first-word-fall-through).
fifo_count  output  ADDR_W+1  number of bytes stored, 0..DEPTH.
half_pending  output  1  low nibble held, waiting for high nibble.
overflow  output  1  sticky: a completed byte was dropped because FIFO was full.
seq_err  output  1  sticky: a nibble broke the +1 sequence.
clr_err  input  1  one-cycle pulse: clears overflow and seq_err and disarms the sequence check.

Behaviour:
- Reset (async assert, sync-to-clk_b release by upstream): pointers 0, fifo_count 0, out_valid 0, out_data 0 (mem content don't-care, but out_data must read 0 while empty after reset), half_pending 0, overflow 0, seq_err 0, checker disarmed.
- Packing, low nibble first:
  - nib_valid with half_pending=0: store nibble as low half; half_pending<=1.
  - nib_valid with half_pending=1: byte = {nib_data, low}; push request this edge; half_pending<=0.
- Push timing: the byte is written at the same edge that samples the second nibble. out_valid and fifo_count reflect it immediately after that edge, so latency is 0 cycles from that edge.
- Pop: at an edge with out_valid=1 and out_ready=1, the head is consumed and rd_ptr advances. out_ready while empty is ignored.
- Pointers: ADDR_W bits, wrap DEPTH-1 -> 0. fifo_count is updated +1 on push only, -1 on pop only, unchanged on both or neither.
- Full (count==DEPTH) with push and no pop: byte dropped, pointers unchanged, overflow<=1.
- Full with push and pop at the same edge: both happen; count stays DEPTH; no overflow.
- Empty with push and out_ready at the same edge: push only, because the pop needs out_valid high before the edge.
- Sequence checker:
  - Disarmed: the first nib_valid loads expected = nib_data+1 (4-bit wrap, F->0) and arms the checker.
  - Armed: if nib_data != expected, seq_err<=1. In all cases expected <= nib_data+1, so the checker resyncs.
  - A nibble that breaks the sequence is still packed normally.
- clr_err:
  - Clears overflow and seq_err, and disarms the checker.
  - If an error event coincides with clr_err at the same edge, set wins.
  - clr_err does not affect FIFO contents or half_pending.
- No flush. Only rst_n empties the FIFO or drops a pending half.
- Assertion of rst_n mid-stream immediately returns all state to the reset values, including any pending half.

Test Plan:
- Basic pack: after reset, nibbles 1,2 (pulses 5 cycles apart) -> half_pending 1 after first; out_valid=1, out_data=8'h21, fifo_count=1 right after second edge; no errors.
- Wrap and order: nibbles E,F,0,1 with out_ready=0 -> two entries 8'hFE then 8'h10; seq_err stays 0 across F->0; out_ready=1 pops FE then 10, count 2->1->0.
- Overflow (ADDR_W=2): out_ready=0, push 5 bytes (nibbles 0..9) -> count=4, overflow=1, fifth byte 8'h98 absent; drain yields 10,32,54,76.
- Full simultaneous push/pop: FIFO full, out_ready=1 on the edge of the 2nd nibble -> count stays 4, overflow=0, new byte at tail.
- Sequence error: nibbles 3,4,7,8 -> seq_err=1 at 7 and no new error at 8. Then clr_err pulse, then nibbles 2,3 -> seq_err stays 0 (rearm on 2). clr_err coincident with a bad nibble -> seq_err=1.
- Reset mid-operation: half_pending=1, count=3, assert rst_n low asynchronously -> all outputs 0 before next clk_b edge; after release, nibbles A,B give 8'hBA.
